wb_arbiter2: RTL and testbench

Two-controller Wishbone classic arbiter forming the shared interconnect between the CPU and a single memory/peripheral bus. It merges the CPU instruction port (port 0) and data port (port 1) onto one Peripheral-side bus, so one `wbram`/`wbram_withgpio` instance can serve both. It arbitrates round-robin, holds the grant for a whole transaction, and runs a watchdog that answers `err` when the peripheral never acknowledges.

---
 rtl/wb_arb_pkg.sv | 6 +
 rtl/wishbone.sv | 24 ++
 rtl/wb_arbiter2.sv | 95 +++++++++
 tb/tb_wb_arbiter2.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-controller Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

endpackage

// File: rtl/wishbone.sv
// Wishbone classic bundle; Controller drives the request, Peripheral answers it.
interface Wishbone;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport Controller (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport Peripheral (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter merging two Wishbone controllers onto one bus, holding
// the grant for a whole transaction, with a no-ack watchdog that answers err.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    Wishbone.Peripheral c0_wb,
    Wishbone.Peripheral c1_wb,
    Wishbone.Controller p_wb,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic WD_ON = (TIMEOUT_CYCLES != 0);

    arb_state_t       state;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] cnt;

    logic        req0, req1, pick, busy, p_done, wd_fire;
    logic        own_cyc, own_stb, own_we;
    logic [31:0] own_adr, own_dat_w;
    logic [3:0]  own_sel;

    assign req0 = c0_wb.cyc & c0_wb.stb;
    assign req1 = c1_wb.cyc & c1_wb.stb;
    // Port 1 wins when alone, or on a tie when port 0 had the last grant.
    assign pick = req1 & (~req0 | ~last);
    assign busy = (state == ARB_BUSY);

    always_comb begin
        own_cyc   = owner ? c1_wb.cyc   : c0_wb.cyc;
        own_stb   = owner ? c1_wb.stb   : c0_wb.stb;
        own_we    = owner ? c1_wb.we    : c0_wb.we;
        own_adr   = owner ? c1_wb.adr   : c0_wb.adr;
        own_dat_w = owner ? c1_wb.dat_w : c0_wb.dat_w;
        own_sel   = owner ? c1_wb.sel   : c0_wb.sel;
    end

    assign p_done  = p_wb.ack | p_wb.err;
    // A real peripheral answer in the limit cycle takes precedence over the watchdog.
    assign wd_fire = busy & WD_ON & (cnt == CNT_LIMIT) & ~p_done;

    assign p_wb.cyc   = busy & own_cyc & ~wd_fire;
    assign p_wb.stb   = busy & own_stb & ~wd_fire;
    assign p_wb.we    = own_we;
    assign p_wb.adr   = own_adr;
    assign p_wb.dat_w = own_dat_w;
    assign p_wb.sel   = own_sel;

    assign c0_wb.ack   = busy & ~owner & p_wb.ack;
    assign c1_wb.ack   = busy &  owner & p_wb.ack;
    assign c0_wb.err   = busy & ~owner & (p_wb.err | wd_fire);
    assign c1_wb.err   = busy &  owner & (p_wb.err | wd_fire);
    assign c0_wb.dat_r = p_wb.dat_r;
    assign c1_wb.dat_r = p_wb.dat_r;

    assign o_grant   = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign o_timeout = wd_fire;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ARB_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (req0 | req1) begin
                        state <= ARB_BUSY;
                        owner <= pick;
                        last  <= pick;
                        cnt   <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (p_done | ~own_cyc | wd_fire) begin
                        state <= ARB_IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2 with an 8-cycle watchdog.
module tb_wb_arbiter2;

    logic       i_clk;
    logic       i_rst_n;
    logic [1:0] o_grant;
    logic       o_timeout;
    int         n_checks;
    int         n_fail;

    Wishbone c0_bus ();
    Wishbone c1_bus ();
    Wishbone p_bus ();

    wb_arbiter2 #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .c0_wb     (c0_bus),
        .c1_wb     (c1_bus),
        .p_wb      (p_bus),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic c0_req(input logic on, input logic [31:0] adr);
        c0_bus.cyc = on; c0_bus.stb = on; c0_bus.we = 1'b0;
        c0_bus.adr = adr; c0_bus.dat_w = 32'h0; c0_bus.sel = 4'hF;
    endtask

    task automatic c1_req(input logic on, input logic [31:0] adr);
        c1_bus.cyc = on; c1_bus.stb = on; c1_bus.we = 1'b1;
        c1_bus.adr = adr; c1_bus.dat_w = 32'h1234_5678; c1_bus.sel = 4'hC;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        c0_req(1'b0, 32'h0);
        c1_req(1'b0, 32'h0);
        p_bus.ack = 1'b0; p_bus.err = 1'b0; p_bus.dat_r = 32'h0;
        step();
        step();
        i_rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_rst_n  = 1'b0;
        c0_req(1'b0, 32'h0);
        c1_req(1'b0, 32'h0);
        p_bus.ack = 1'b0; p_bus.err = 1'b0; p_bus.dat_r = 32'h0;
        #3;
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_timeout", 32'(o_timeout), 32'h0);
        check("rst_pcyc", 32'(p_bus.cyc), 32'h0);
        check("rst_c0ack", 32'(c0_bus.ack), 32'h0);
        do_reset();

        // Port 0 alone, peripheral acks 3 cycles after stb
        c0_req(1'b1, 32'h1000_0004);
        #1;
        check("a_idle_stb", 32'(p_bus.stb), 32'h0);
        step();
        check("a_grant", 32'(o_grant), 32'h1);
        check("a_stb", 32'(p_bus.stb), 32'h1);
        check("a_adr", p_bus.adr, 32'h1000_0004);
        check("a_sel", 32'(p_bus.sel), 32'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            check("a_wait_ack", 32'(c0_bus.ack), 32'h0);
        end
        p_bus.ack = 1'b1; p_bus.dat_r = 32'hCAFE_0001;
        #1;
        check("a_c0ack", 32'(c0_bus.ack), 32'h1);
        check("a_c1ack", 32'(c1_bus.ack), 32'h0);
        check("a_dat_r", c0_bus.dat_r, 32'hCAFE_0001);
        check("a_dat_r_bcast", c1_bus.dat_r, 32'hCAFE_0001);
        step();
        p_bus.ack = 1'b0;
        c0_req(1'b0, 32'h0);
        #1;
        check("a_grant_end", 32'(o_grant), 32'h0);

        // Both request from reset
        do_reset();
        c0_req(1'b1, 32'h1000_0004);
        c1_req(1'b1, 32'h4000_0010);
        step();
        check("b_grant0", 32'(o_grant), 32'h1);
        check("b_adr0", p_bus.adr, 32'h1000_0004);
        p_bus.ack = 1'b1;
        #1;
        check("b_c0ack", 32'(c0_bus.ack), 32'h1);
        check("b_c1ack_blocked", 32'(c1_bus.ack), 32'h0);
        step();
        p_bus.ack = 1'b0;
        c0_req(1'b0, 32'h0);
        #1;
        check("b_bubble_grant", 32'(o_grant), 32'h0);
        check("b_bubble_stb", 32'(p_bus.stb), 32'h0);
        step();
        check("b_grant1", 32'(o_grant), 32'h2);
        check("b_adr1", p_bus.adr, 32'h4000_0010);
        check("b_we1", 32'(p_bus.we), 32'h1);
        check("b_datw1", p_bus.dat_w, 32'h1234_5678);
        check("b_sel1", 32'(p_bus.sel), 32'hC);
        p_bus.ack = 1'b1;
        #1;
        check("b_c1ack", 32'(c1_bus.ack), 32'h1);
        check("b_c0ack_none", 32'(c0_bus.ack), 32'h0);
        step();
        p_bus.ack = 1'b0;
        c1_req(1'b0, 32'h0);
        #1;

        // Three rounds of continuous contention
        c0_req(1'b1, 32'h1000_0004);
        c1_req(1'b1, 32'h4000_0010);
        for (int i = 0; i < 6; i++) begin
            step();
            check("c_grant", 32'(o_grant), (i % 2 == 0) ? 32'h1 : 32'h2);
            p_bus.ack = 1'b1;
            #1;
            check("c_c0ack", 32'(c0_bus.ack), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("c_c1ack", 32'(c1_bus.ack), (i % 2 == 0) ? 32'h0 : 32'h1);
            step();
            p_bus.ack = 1'b0;
            #1;
            check("c_bubble", 32'(o_grant), 32'h0);
        end

        // Watchdog: port 1 alone, peripheral never answers
        c0_req(1'b0, 32'h0);
        step();
        check("d_grant", 32'(o_grant), 32'h2);
        for (int k = 0; k < 8; k++) begin
            check("d_cyc_held", 32'(p_bus.cyc), 32'h1);
            check("d_no_timeout", 32'(o_timeout), 32'h0);
            step();
        end
        check("d_cyc_drop", 32'(p_bus.cyc), 32'h0);
        check("d_c1err", 32'(c1_bus.err), 32'h1);
        check("d_c0err", 32'(c0_bus.err), 32'h0);
        check("d_timeout", 32'(o_timeout), 32'h1);
        c1_req(1'b0, 32'h0);
        c0_req(1'b1, 32'h1000_0004);
        step();
        check("d_idle_grant", 32'(o_grant), 32'h0);
        check("d_timeout_pulse", 32'(o_timeout), 32'h0);
        step();
        check("d_next_grant", 32'(o_grant), 32'h1);
        p_bus.ack = 1'b1;
        #1;
        check("d_next_ack", 32'(c0_bus.ack), 32'h1);
        step();
        p_bus.ack = 1'b0;
        c0_req(1'b0, 32'h0);
        #1;

        // Ack lands exactly in the watchdog limit cycle
        c1_req(1'b1, 32'h4000_0010);
        step();
        for (int k = 0; k < 8; k++) step();
        p_bus.ack = 1'b1;
        #1;
        check("e_ack", 32'(c1_bus.ack), 32'h1);
        check("e_no_err", 32'(c1_bus.err), 32'h0);
        check("e_no_timeout", 32'(o_timeout), 32'h0);
        check("e_cyc", 32'(p_bus.cyc), 32'h1);
        step();
        p_bus.ack = 1'b0;
        c1_req(1'b0, 32'h0);
        #1;
        check("e_idle", 32'(o_grant), 32'h0);

        // Reset asserted mid-transaction
        c0_req(1'b1, 32'h1000_0004);
        step();
        check("f_cyc_busy", 32'(p_bus.cyc), 32'h1);
        p_bus.ack = 1'b1;
        #1;
        i_rst_n = 1'b0;
        #1;
        check("f_cyc_async", 32'(p_bus.cyc), 32'h0);
        check("f_c0ack", 32'(c0_bus.ack), 32'h0);
        check("f_grant_rst", 32'(o_grant), 32'h0);
        p_bus.ack = 1'b0;
        c1_req(1'b1, 32'h4000_0010);
        step();
        i_rst_n = 1'b1;
        #1;
        check("f_grant_release", 32'(o_grant), 32'h0);
        step();
        check("f_first_tie", 32'(o_grant), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
